// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - round-robin arbiter owning the select of a shared 8:1 mux
module rr_mux_arbiter #(
    parameter int MAX_HOLD = 15
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] Req,
    input  logic       Done,
    output logic [7:0] Gnt,
    output logic [2:0] S,
    output logic       Busy,
    output logic       TO
);

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_e;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_e     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] s_q, s_d;
    logic       to_q, to_d;

    logic [15:0] req_dbl;
    logic [7:0]  req_rot;
    logic [2:0]  pick_ofs;
    logic [2:0]  pick_idx;
    logic        owner_req;
    logic        hold_hit;

    // Rotate so the pointer position lands at bit 0; the lowest set bit is then the winner.
    assign req_dbl  = {Req, Req};
    assign req_rot  = 8'(req_dbl >> ptr_q);
    assign pick_idx = ptr_q + pick_ofs;

    always_comb begin
        pick_ofs = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req_rot[i]) begin
                pick_ofs = 3'(i);
            end
        end
    end

    assign owner_req = Req[s_q];
    assign hold_hit  = (cnt_q == HOLD_LAST);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        s_d     = s_q;
        to_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (|Req) begin
                    state_d = ST_GRANT;
                    gnt_d   = 8'd1 << pick_idx;
                    s_d     = pick_idx;
                    cnt_d   = 8'd0;
                end
            end
            ST_GRANT: begin
                if (Done || !owner_req || hold_hit) begin
                    // S is left on the old owner so the mux select does not glitch while idle.
                    state_d = ST_IDLE;
                    gnt_d   = 8'd0;
                    ptr_d   = s_q + 3'd1;
                    to_d    = !Done && owner_req;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= 3'd0;
            cnt_q   <= 8'd0;
            gnt_q   <= 8'd0;
            s_q     <= 3'd0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            s_q     <= s_d;
            to_q    <= to_d;
        end
    end

    assign Gnt  = gnt_q;
    assign S    = s_q;
    assign Busy = (state_q == ST_GRANT);
    assign TO   = to_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - directed and randomized checks of rr_mux_arbiter against a reference model
module tb_rr_mux_arbiter;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] Req   = 8'h00;
    logic       Done  = 1'b0;

    logic [7:0] gnt_a, gnt_b;
    logic [2:0] s_a, s_b;
    logic       busy_a, busy_b, to_a, to_b;

    rr_mux_arbiter #(.MAX_HOLD(15)) dut (
        .Clock(Clock), .Reset(Reset), .Req(Req), .Done(Done),
        .Gnt(gnt_a), .S(s_a), .Busy(busy_a), .TO(to_a)
    );

    rr_mux_arbiter #(.MAX_HOLD(4)) dut4 (
        .Clock(Clock), .Reset(Reset), .Req(Req), .Done(Done),
        .Gnt(gnt_b), .S(s_b), .Busy(busy_b), .TO(to_b)
    );

    always #5 Clock = ~Clock;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Model state per instance: 0 -> MAX_HOLD=15, 1 -> MAX_HOLD=4.
    int m_busy[2] = '{0, 0};
    int m_s[2]    = '{0, 0};
    int m_ptr[2]  = '{0, 0};
    int m_len[2]  = '{0, 0};
    int m_to[2]   = '{0, 0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step(input int i, input int mh);
        if (Reset) begin
            m_busy[i] = 0; m_s[i] = 0; m_ptr[i] = 0; m_len[i] = 0; m_to[i] = 0;
            return;
        end
        m_to[i] = 0;
        if (m_busy[i] != 0) begin
            if (Done || !Req[m_s[i]] || m_len[i] == mh) begin
                if (!Done && Req[m_s[i]]) m_to[i] = 1;
                m_busy[i] = 0;
                m_ptr[i]  = (m_s[i] + 1) % 8;
            end else begin
                m_len[i]++;
            end
        end else if (Req != 8'h00) begin
            for (int j = 0; j < 8; j++) begin
                int k;
                k = (m_ptr[i] + j) % 8;
                if (Req[k]) begin
                    m_busy[i] = 1; m_s[i] = k; m_len[i] = 1;
                    break;
                end
            end
        end
    endtask

    task automatic cmp_inst(input string tag, input int i, input logic [7:0] g,
                            input logic [2:0] s, input logic b, input logic t);
        logic [7:0] eg;
        eg = (m_busy[i] != 0) ? (8'd1 << m_s[i]) : 8'd0;
        chk({tag, "_gnt"}, g, eg);
        chk({tag, "_s"}, s, m_s[i]);
        chk({tag, "_busy"}, b, m_busy[i]);
        chk({tag, "_to"}, t, m_to[i]);
        chk({tag, "_onehot0"}, $onehot0(g), 1);
    endtask

    // Outputs are compared at the falling edge; the model then advances on the inputs the next rising edge will sample.
    initial begin
        forever begin
            @(negedge Clock);
            if (chk_en) begin
                cmp_inst("m15", 0, gnt_a, s_a, busy_a, to_a);
                cmp_inst("m4", 1, gnt_b, s_b, busy_b, to_b);
            end
            step(0, 15);
            step(1, 4);
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        Done  = 1'b0;
        tick();
        Reset = 1'b0;
    endtask

    task automatic wait_grant(input bit use4);
        int n;
        n = 0;
        while (((use4 ? gnt_b : gnt_a) == 8'h00) && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) chk("grant_wait_timeout", 0, 1);
    endtask

    initial begin
        int len;
        int pdone;
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        chk_en = 1'b1;

        // Idle after reset with no requests.
        for (int c = 0; c < 5; c++) begin
            chk("idle_gnt", gnt_a, 8'h00);
            chk("idle_s", s_a, 3'd0);
            chk("idle_busy", busy_a, 1'b0);
            chk("idle_to", to_a, 1'b0);
            tick();
        end

        // Two requesters alternate with a single idle cycle between grants.
        do_reset();
        Req = 8'h24;
        wait_grant(0);
        for (int g = 0; g < 4; g++) begin
            chk("alt_gnt", gnt_a, (g % 2 == 0) ? 8'h04 : 8'h20);
            chk("alt_s", s_a, (g % 2 == 0) ? 3'd2 : 3'd5);
            tick();
            tick();
            Done = 1'b1;
            tick();
            Done = 1'b0;
            chk("alt_gap", gnt_a, 8'h00);
            tick();
        end

        // All requesting: select walks 0..7 then wraps to 0.
        do_reset();
        Req = 8'hFF;
        wait_grant(0);
        for (int g = 0; g < 9; g++) begin
            chk("wrap_s", s_a, g % 8);
            chk("wrap_gnt", gnt_a, 8'd1 << (g % 8));
            Done = 1'b1;
            tick();
            Done = 1'b0;
            chk("wrap_gap", gnt_a, 8'h00);
            tick();
        end

        // Hold-time limit on the MAX_HOLD=4 instance.
        do_reset();
        Req = 8'h08;
        wait_grant(1);
        len = 0;
        while (gnt_b == 8'h08 && len < 20) begin
            len++;
            tick();
        end
        chk("hold_len", len, 4);
        chk("hold_gnt_off", gnt_b, 8'h00);
        chk("hold_to", to_b, 1'b1);
        tick();
        chk("hold_regrant", gnt_b, 8'h08);
        chk("hold_to_clear", to_b, 1'b0);

        // Reset in the middle of a grant.
        do_reset();
        Req = 8'h20;
        wait_grant(0);
        chk("mid_gnt", gnt_a, 8'h20);
        tick();
        Reset = 1'b1;
        tick();
        chk("mid_rst_gnt", gnt_a, 8'h00);
        chk("mid_rst_s", s_a, 3'd0);
        chk("mid_rst_to", to_a, 1'b0);
        chk("mid_rst_busy", busy_a, 1'b0);
        Reset = 1'b0;
        Req = 8'hFF;
        tick();
        chk("post_rst_s", s_a, 3'd0);
        chk("post_rst_gnt", gnt_a, 8'h01);

        // Owner drops its request: release without timeout, pointer moves past it.
        do_reset();
        Req = 8'h40;
        wait_grant(0);
        chk("drop_s", s_a, 3'd6);
        tick();
        Req = 8'h81;
        tick();
        chk("drop_gnt_off", gnt_a, 8'h00);
        chk("drop_to", to_a, 1'b0);
        tick();
        chk("drop_next_s", s_a, 3'd7);
        chk("drop_next_gnt", gnt_a, 8'h80);

        // Randomized traffic; low Done rate in the second half reaches the MAX_HOLD=15 limit.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            pdone = (c < 2000) ? 20 : 2;
            if ($urandom_range(0, 9) == 0) Req = 8'($urandom_range(0, 255));
            Done  = ($urandom_range(0, 99) < pdone);
            Reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        Reset = 1'b0;
        Done  = 1'b0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
